// File: rtl/dot_product_acc.sv
// Two-stage dot-product accumulator: operands are registered toward an external
// 8x8 multiplier, and the returned product is summed into a wrapping accumulator.
//
// state | meaning
// RUN   | accepting operand pairs, accumulator follows the live sum
// DONE  | result held on out_* until the consumer takes it
module dot_product_acc #(
   parameter int ACC_W = 20,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_x,
   input  logic [7:0]       in_y,
   input  logic             in_last,
   output logic [7:0]       mul_x,
   output logic [7:0]       mul_y,
   input  logic [15:0]      mul_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             op_valid;
   logic             op_last;
   logic [7:0]       op_x;
   logic [7:0]       op_y;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             in_fire;
   logic             out_fire;
   logic [ACC_W:0]   sum_w;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign sum_w    = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, mul_p};

   assign mul_x     = op_x;
   assign mul_y     = op_y;
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A pending last term blocks intake so the next dot product never mixes in.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         RUN: begin
            in_ready = !(op_valid && op_last);
            if (op_valid && op_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_valid <= 1'b0;
         op_last  <= 1'b0;
         op_x     <= '0;
         op_y     <= '0;
      end else begin
         op_valid <= in_fire;
         if (in_fire) begin
            op_x    <= in_x;
            op_y    <= in_y;
            op_last <= in_last;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (out_fire) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (op_valid) begin
         acc_q <= sum_w[ACC_W-1:0];
         if (sum_w[ACC_W]) begin
            ovf_q <= 1'b1;
         end
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc with a behavioural multiplier on mul_x/mul_y.
module tb_dot_product_acc;

   localparam int ACC_W = 20;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_x;
   logic [7:0]       in_y;
   logic             in_last;
   logic [7:0]       mul_x;
   logic [7:0]       mul_y;
   logic [15:0]      mul_p;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int n_cmp;
   int n_err;
   int stalls;

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic        last;
      int          gap;
      int          hold;
      logic [31:0] sum;
      logic [31:0] cnt;
      logic [31:0] ovf;
   } vec_t;

   vec_t vecs[$];

   dot_product_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_last   (in_last),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   assign mul_p = 16'(mul_x) * 16'(mul_y);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_term(input logic [7:0] x, input logic [7:0] y, input logic last);
      int waits;
      waits    = 0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      in_last  = last;
      while (!in_ready && waits < 50) begin
         tick();
         waits++;
      end
      if (waits >= 50) chk("in_ready_timeout", 32'(waits), 32'd0);
      stalls += waits;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the last-term handshake edge.
   task automatic collect(input string name, input logic [31:0] sum, input logic [31:0] cnt,
                          input logic [31:0] ovf, input int hold);
      logic [7:0] held_x;
      chk({name, "_valid_lat0"}, 32'(out_valid), 32'd0);
      chk({name, "_ready_pend"}, 32'(in_ready), 32'd0);
      tick();
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_sum"}, 32'(out_sum), sum);
      chk({name, "_count"}, 32'(out_count), cnt);
      chk({name, "_ovf"}, 32'(out_ovf), ovf);
      held_x = mul_x;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_x     = 8'd9;
         in_y     = 8'd9;
         tick();
         chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_hold_sum"}, 32'(out_sum), sum);
         chk({name, "_hold_count"}, 32'(out_count), cnt);
         chk({name, "_hold_ovf"}, 32'(out_ovf), ovf);
         chk({name, "_hold_ready"}, 32'(in_ready), 32'd0);
         chk({name, "_hold_mulx"}, 32'(mul_x), 32'(held_x));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_valid_clr"}, 32'(out_valid), 32'd0);
      chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
      chk({name, "_sum_clr"}, 32'(out_sum), 32'd0);
      chk({name, "_count_clr"}, 32'(out_count), 32'd0);
   endtask

   task automatic add_vec(input logic [7:0] x, input logic [7:0] y, input logic last, input int gap,
                          input logic [31:0] sum, input logic [31:0] cnt, input logic [31:0] ovf);
      vec_t v;
      v.x = x; v.y = y; v.last = last; v.gap = gap; v.hold = 0;
      v.sum = sum; v.cnt = cnt; v.ovf = ovf;
      vecs.push_back(v);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      stalls    = 0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      add_vec(8'd255, 8'd255, 1'b1, 0, 32'd65025, 32'd1, 32'd0);
      add_vec(8'd1, 8'd2, 1'b0, 0, 0, 0, 0);
      add_vec(8'd3, 8'd4, 1'b0, 0, 0, 0, 0);
      add_vec(8'd5, 8'd6, 1'b0, 0, 0, 0, 0);
      add_vec(8'd7, 8'd8, 1'b1, 0, 32'd100, 32'd4, 32'd0);
      for (int i = 0; i < 16; i++) add_vec(8'd255, 8'd255, 1'b0, 0, 0, 0, 0);
      add_vec(8'd255, 8'd255, 1'b1, 0, 32'd56849, 32'd17, 32'd1);
      add_vec(8'd10, 8'd10, 1'b0, 0, 0, 0, 0);
      add_vec(8'd1, 8'd1, 1'b1, 2, 32'd101, 32'd2, 32'd0);
      add_vec(8'd0, 8'd0, 1'b1, 0, 32'd0, 32'd1, 32'd0);

      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      chk("rst_mulx", 32'(mul_x), 32'd0);
      #10;
      reset_n = 1'b1;
      tick();
      chk("rst_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         for (int g = 0; g < vecs[i].gap; g++) tick();
         send_term(vecs[i].x, vecs[i].y, vecs[i].last);
         if (vecs[i].last) collect($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cnt, vecs[i].ovf, 0);
      end
      chk("no_stall", 32'(stalls), 32'd0);

      send_term(8'd4, 8'd5, 1'b1);
      collect("bp", 32'd20, 32'd1, 32'd0, 5);
      send_term(8'd2, 8'd3, 1'b1);
      collect("after_bp", 32'd6, 32'd1, 32'd0, 0);

      send_term(8'd1, 8'd1, 1'b0);
      send_term(8'd2, 8'd2, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_sum", 32'(out_sum), 32'd0);
      chk("arst_count", 32'(out_count), 32'd0);
      chk("arst_ovf", 32'(out_ovf), 32'd0);
      chk("arst_mulx", 32'(mul_x), 32'd0);
      chk("arst_muly", 32'(mul_y), 32'd0);
      #1;
      reset_n = 1'b1;
      tick();
      send_term(8'd3, 8'd3, 1'b1);
      collect("post_rst", 32'd9, 32'd1, 32'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
